// File: rtl/sumador_serial.sv
// sumador_serial: bit-serial N-bit adder, one full-adder cell plus a carry
// flip-flop, LSB first. Operands and carry-in are captured on an accepted
// start; sum and carry-out are registered on the final bit and flagged by a
// one-cycle done pulse. Reconstructs a from a restador difference.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active-low
//   start         request, honoured only in IDLE or DONE
//   a, b          N-bit operands, captured when start is accepted
//   cin           carry-in, captured when start is accepted
//   busy          high while bits are being processed
//   done          one-cycle pulse, result valid from this cycle
//   s_sumador     registered sum, a + b + cin mod 2^N
//   cout_sumador  registered carry-out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, result registers hold last value
// RUN   | one bit per edge, exits on the edge that processes the MSB
// DONE  | single cycle with done=1; start here is accepted back-to-back
module sumador_serial #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] s_sumador,
   output logic         cout_sumador
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [N-1:0]  sum_sh;
   logic          carry;
   logic [CW-1:0] cnt;

   logic          bit_s;
   logic          carry_nx;
   logic [N-1:0]  sum_nx;

   assign bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
   // Sum bits enter at the MSB so after N shifts bit 0 sits at position 0.
   assign sum_nx   = {bit_s, sum_sh[N-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_sh         <= '0;
         b_sh         <= '0;
         sum_sh       <= '0;
         carry        <= 1'b0;
         cnt          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         s_sumador    <= '0;
         cout_sumador <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  carry  <= cin;
                  sum_sh <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh   <= {1'b0, a_sh[N-1:1]};
               b_sh   <= {1'b0, b_sh[N-1:1]};
               carry  <= carry_nx;
               sum_sh <= sum_nx;
               cnt    <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  // Publish from the next-value nets so the MSB is included.
                  s_sumador    <= sum_nx;
                  cout_sumador <= carry_nx;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  state        <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sumador_serial.sv
module tb_sumador_serial;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] s_sumador;
   logic         cout_sumador;

   typedef struct packed {
      logic [N-1:0] s;
      logic         c;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   done_seen = 0;

   sumador_serial #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .a            (a),
      .b            (b),
      .cin          (cin),
      .busy         (busy),
      .done         (done),
      .s_sumador    (s_sumador),
      .cout_sumador (cout_sumador)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
      logic [N:0] full;
      exp_t e;
      full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
      e.s = full[N-1:0];
      e.c = full[N];
      return e;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         done_seen++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum", {28'd0, s_sumador}, {28'd0, e.s});
            check("cout", {31'd0, cout_sumador}, {31'd0, e.c});
         end
      end
   end

   // Called at a negedge: pulses start for one edge, then waits for done.
   task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci,
                         output int lat, output int busy_cnt);
      a = x; b = y; cin = ci; start = 1'b1;
      sb.push_back(model(x, y, ci));
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int lat, bc, d0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {28'd0, s_sumador}, 32'd0);
      check("rst_cout", {31'd0, cout_sumador}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic operation with latency and busy width.
      run_op(4'd3, 4'd5, 1'b0, lat, bc);
      check("latency", lat, 32'd5);
      check("busy_cycles", bc, 32'd4);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);

      run_op(4'd15, 4'd1, 1'b0, lat, bc);
      run_op(4'd7, 4'd8, 1'b1, lat, bc);
      run_op(4'd3, 4'd6, 1'b0, lat, bc);   // round trip of a restador result

      // start held high with operands changing every cycle.
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = N'($urandom_range(0, 15));
         b = N'($urandom_range(0, 15));
         cin = 1'($urandom_range(0, 1));
         if (i % 5 == 0) sb.push_back(model(a, b, cin));
         @(negedge clk);
         check("cont_done", {31'd0, done}, {31'd0, (i % 5 == 4)});
         check("cont_busy", {31'd0, busy}, {31'd0, (i % 5 != 4)});
      end
      start = 1'b0;
      @(negedge clk);

      // start while busy is ignored.
      a = 4'd10; b = 4'd4; cin = 1'b1; start = 1'b1;
      sb.push_back(model(4'd10, 4'd4, 1'b1));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd1; b = 4'd1; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 4'd2; b = 4'd2;
      lat = 3;
      while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      check("midrun_latency", lat, 32'd5);
      @(negedge clk);
      check("midrun_no_restart", {31'd0, busy}, 32'd0);
      check("midrun_queue_empty", sb.size(), 32'd0);

      // Asynchronous reset after two bits of a run.
      a = 4'd9; b = 4'd9; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_sum", {28'd0, s_sumador}, 32'd0);
      check("arst_cout", {31'd0, cout_sumador}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_seen;
      repeat (10) @(negedge clk);
      check("no_done_after_reset", done_seen - d0, 32'd0);
      check("idle_after_reset", {31'd0, busy}, 32'd0);
      run_op(4'd12, 4'd7, 1'b1, lat, bc);

      // Exhaustive sweep, back-to-back through DONE.
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++)
               run_op(N'(x), N'(y), 1'(c), lat, bc);
      @(negedge clk);
      check("final_queue_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
